// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between the four requesters and mux4_rr_arbiter.
// Optional lock signal is present only when MUX4_ARB_LOCK_EN is defined.
interface mux4_rr_arbiter_if #(
   parameter int CNT_W = 3
);
   logic [3:0]       req;
   logic [3:0]       gnt;
   logic             sel_a;
   logic             sel_b;
   logic             mux_en;
   logic [CNT_W-1:0] hold_cnt;
   logic             timeout;
`ifdef MUX4_ARB_LOCK_EN
   logic             lock;

   modport master (output req, lock, input gnt, sel_a, sel_b, mux_en, hold_cnt, timeout);
   modport slave  (input req, lock, output gnt, sel_a, sel_b, mux_en, hold_cnt, timeout);
`else
   modport master (output req, input gnt, sel_a, sel_b, mux_en, hold_cnt, timeout);
   modport slave  (input req, output gnt, sel_a, sel_b, mux_en, hold_cnt, timeout);
`endif
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbiter for the shared 4:1 mux with a MAX_HOLD timeout.
// Optional feature macro: MUX4_ARB_LOCK_EN (adds lock, suppresses timeout while held).
module mux4_rr_arbiter #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = $clog2(MAX_HOLD)
) (
   input  logic              clk,
   input  logic              rst_n,
   mux4_rr_arbiter_if.slave  bus
);

   typedef enum logic {IDLE, GRANT} state_e;

   state_e           state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       owner_q, owner_d;
   logic             mux_en_q, mux_en_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             timeout_q, timeout_d;
   logic [1:0]       ptr_q, ptr_d;

   logic       lock_on;
   logic [1:0] rel_ptr;
   logic [2:0] pick_idle, pick_rel;
   logic       owner_req, at_max, expire;

`ifdef MUX4_ARB_LOCK_EN
   assign lock_on = bus.lock;
`else
   assign lock_on = 1'b0;
`endif

   // Returns {found, index}: first set bit of r scanning upward from p with wrap.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         idx = p + 2'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign rel_ptr   = owner_q + 2'd1;
   assign pick_idle = rr_pick(bus.req, ptr_q);
   assign pick_rel  = rr_pick(bus.req, rel_ptr);
   assign owner_req = bus.req[owner_q];
   assign at_max    = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
   assign expire    = at_max && !lock_on;

   always_comb begin
      // NOTE: every _d gets a default first so no path through the case infers a latch.
      state_d    = state_q;
      gnt_d      = gnt_q;
      owner_d    = owner_q;
      mux_en_d   = mux_en_q;
      hold_cnt_d = hold_cnt_q;
      timeout_d  = 1'b0;
      ptr_d      = ptr_q;

      unique case (state_q)
         IDLE: begin
            if (pick_idle[2]) begin
               state_d    = GRANT;
               owner_d    = pick_idle[1:0];
               gnt_d      = 4'b0001 << pick_idle[1:0];
               mux_en_d   = 1'b1;
               hold_cnt_d = '0;
            end
         end
         GRANT: begin
            if (!owner_req || expire) begin
               // A release with the owner still requesting can only be an expiry.
               ptr_d      = rel_ptr;
               timeout_d  = owner_req;
               hold_cnt_d = '0;
               if (pick_rel[2]) begin
                  owner_d = pick_rel[1:0];
                  gnt_d   = 4'b0001 << pick_rel[1:0];
               end else begin
                  state_d  = IDLE;
                  gnt_d    = 4'b0000;
                  mux_en_d = 1'b0;
               end
            end else if (!at_max) begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gnt_q      <= 4'b0000;
         owner_q    <= 2'd0;
         mux_en_q   <= 1'b0;
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
         ptr_q      <= 2'd0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         owner_q    <= owner_d;
         mux_en_q   <= mux_en_d;
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
         ptr_q      <= ptr_d;
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.sel_a    = owner_q[0];
   assign bus.sel_b    = owner_q[1];
   assign bus.mux_en   = mux_en_q;
   assign bus.hold_cnt = hold_cnt_q;
   assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed-vector bench for mux4_rr_arbiter (MAX_HOLD=8); inputs change and
// outputs are checked on the falling edge of clk.
module tb_mux4_rr_arbiter;

   localparam int MAX_HOLD = 8;
   localparam int CNT_W    = 3;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   mux4_rr_arbiter_if #(.CNT_W(CNT_W)) bus_if ();

   mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] sel,
                             input logic [2:0] cnt, input logic to);
      check({tag, ".gnt"},      32'(bus_if.gnt), 32'(g));
      check({tag, ".sel"},      32'({bus_if.sel_b, bus_if.sel_a}), 32'(sel));
      check({tag, ".mux_en"},   32'(bus_if.mux_en), 32'(g != 4'b0000));
      check({tag, ".hold_cnt"}, 32'(bus_if.hold_cnt), 32'(cnt));
      check({tag, ".timeout"},  32'(bus_if.timeout), 32'(to));
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus_if.req = 4'b0000;
`ifdef MUX4_ARB_LOCK_EN
      bus_if.lock = 1'b0;
`endif
      #2 check_outs("reset", 4'b0000, 2'd0, 3'd0, 1'b0);

      // Rotation from ptr=0; each owner drops its request for the release cycle.
      @(negedge clk);
      rst_n = 1'b1;
      bus_if.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_outs("rotate", 4'b0001 << (k % 4), 2'(k % 4), 3'd0, 1'b0);
         bus_if.req = (k == 4) ? 4'b0000 : (4'b1111 & ~(4'b0001 << (k % 4)));
      end
      @(negedge clk);
      check_outs("rr_idle", 4'b0000, 2'd0, 3'd0, 1'b0);

      // Single requester C, held three cycles, then parked select.
      bus_if.req = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_outs("single", 4'b0100, 2'd2, 3'(k), 1'b0);
      end
      bus_if.req = 4'b0000;
      @(negedge clk);
      check_outs("park", 4'b0000, 2'd2, 3'd0, 1'b0);

      // Two constant requesters alternate on timeout (ptr=3 so A wins first).
      bus_if.req = 4'b0011;
      for (int c = 0; c < 17; c++) begin
         @(negedge clk);
         check_outs("timeout", (c >= 8 && c < 16) ? 4'b0010 : 4'b0001,
                    (c >= 8 && c < 16) ? 2'd1 : 2'd0, 3'(c % 8), (c == 8 || c == 16));
      end

      // Sole requester D is re-granted on each expiry.
      bus_if.req = 4'b1000;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         check_outs("sole", 4'b1000, 2'd3, 3'(c % 8), (c == 8 || c == 16));
      end

      // Owner drops at hold_cnt=7: voluntary, no timeout pulse.
      bus_if.req = 4'b0001;
      @(negedge clk);
      check_outs("simul", 4'b0001, 2'd0, 3'd0, 1'b0);
      bus_if.req = 4'b0010;
      @(negedge clk);
      check_outs("handoff", 4'b0010, 2'd1, 3'd0, 1'b0);

      // Asynchronous reset mid-cycle during a grant; ptr must restart at 0.
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_outs("async_rst", 4'b0000, 2'd0, 3'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      bus_if.req = 4'b1001;
      @(negedge clk);
      check_outs("post_rst", 4'b0001, 2'd0, 3'd0, 1'b0);

`ifdef MUX4_ARB_LOCK_EN
      bus_if.lock = 1'b1;
      bus_if.req  = 4'b0011;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         check_outs("lock", 4'b0001, 2'd0, 3'((k < 7) ? k : 7), 1'b0);
      end
      bus_if.lock = 1'b0;
      @(negedge clk);
      check_outs("unlock", 4'b0010, 2'd1, 3'd0, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
